// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sample input and result output handshake bundle for sum_accumulator
interface sum_accumulator_if #(
    parameter int WIDTH     = 2,
    parameter int OUT_WIDTH = 4
);
    logic                 i_valid;
    logic [WIDTH-1:0]     i_data;
    logic                 o_valid;
    logic                 o_ready;
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_drop;

    // Sample producer / result consumer side
    modport master (
        output i_valid,
        output i_data,
        output o_ready,
        input  o_valid,
        input  o_data,
        input  o_drop
    );

    // Accumulator side
    modport slave (
        input  i_valid,
        input  i_data,
        input  o_ready,
        output o_valid,
        output o_data,
        output o_drop
    );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - groups COUNT samples into one sum, one-deep output register; SUM_ACCUMULATOR_SATURATE_EN selects clamping
module sum_accumulator #(
    parameter int WIDTH     = 2,
    parameter int COUNT     = 4,
    parameter int OUT_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sum_accumulator_if.slave  bus
);
    localparam int CW = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [OUT_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 o_valid_q;
    logic [OUT_WIDTH-1:0] o_data_q;
    logic                 o_drop_q;

    logic [OUT_WIDTH:0]   sum_ext;
    logic [OUT_WIDTH-1:0] sum_next;
    logic                 final_sample;
    logic                 reg_free;

    // One extra bit catches the carry out of the OUT_WIDTH addition
    always_comb begin
        sum_ext = {1'b0, acc} + (OUT_WIDTH + 1)'(bus.i_data);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        // Once clamped, acc sits at all-ones so later additions stay clamped
        sum_next = sum_ext[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : sum_ext[OUT_WIDTH-1:0];
`else
        sum_next = sum_ext[OUT_WIDTH-1:0];
`endif
        final_sample = bus.i_valid && (cnt == LAST);
        // The output register can take a result if empty or being drained this cycle
        reg_free     = !o_valid_q || bus.o_ready;
    end

    // Accumulator, sample counter and output register update
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_drop_q  <= 1'b0;
        end else begin
            o_drop_q <= 1'b0;
            if (o_valid_q && bus.o_ready) begin
                o_valid_q <= 1'b0;
            end
            if (bus.i_valid) begin
                if (final_sample) begin
                    acc <= '0;
                    cnt <= '0;
                    if (reg_free) begin
                        o_valid_q <= 1'b1;
                        o_data_q  <= sum_next;
                    end else begin
                        o_drop_q <= 1'b1;
                    end
                end else begin
                    acc <= sum_next;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_drop  = o_drop_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed and random checks of sum_accumulator at OUT_WIDTH 4 and 3
module tb_sum_accumulator;
    localparam int COUNT = 4;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.WIDTH(2), .OUT_WIDTH(4)) bus4 ();
    sum_accumulator_if #(.WIDTH(2), .OUT_WIDTH(3)) bus3 ();

    sum_accumulator #(.WIDTH(2), .COUNT(COUNT), .OUT_WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    sum_accumulator #(.WIDTH(2), .COUNT(COUNT), .OUT_WIDTH(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Reference model: pending group samples plus expected output per instance
    int q_grp[$];
    int ow[2] = '{4, 3};
    bit ev[2];
    int ed[2];
    bit edrop[2];

    function automatic int group_result(int width);
        int maxv = (1 << width) - 1;
        int s = 0;
        foreach (q_grp[i]) begin
            s = s + q_grp[i];
            if (SAT && s > maxv) s = maxv;
        end
        return s % (maxv + 1);
    endfunction

    task automatic model_step(bit v, int d, bit rdy, bit rs);
        bit done;
        int r;
        if (!rs) begin
            q_grp.delete();
            for (int k = 0; k < 2; k++) begin
                ev[k] = 0; ed[k] = 0; edrop[k] = 0;
            end
            return;
        end
        done = 0;
        if (v) begin
            q_grp.push_back(d);
            done = (q_grp.size() == COUNT);
        end
        for (int k = 0; k < 2; k++) begin
            edrop[k] = 0;
            if (done && (!ev[k] || rdy)) begin
                r = group_result(ow[k]);
                ev[k] = 1;
                ed[k] = r;
            end else begin
                if (done) edrop[k] = 1;
                if (ev[k] && rdy) ev[k] = 0;
            end
        end
        if (done) q_grp.delete();
    endtask

    task automatic chk(string tag, logic [31:0] act, int exp);
        checks++;
        assert (act === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("valid4", 32'(bus4.o_valid), int'(ev[0]));
        chk("drop4", 32'(bus4.o_drop), int'(edrop[0]));
        if (ev[0]) chk("data4", 32'(bus4.o_data), ed[0]);
        chk("valid3", 32'(bus3.o_valid), int'(ev[1]));
        chk("drop3", 32'(bus3.o_drop), int'(edrop[1]));
        if (ev[1]) chk("data3", 32'(bus3.o_data), ed[1]);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check just after it
    task automatic cycle(bit v, int d, bit rdy, bit rs);
        rst          = rs;
        bus4.i_valid = v;
        bus3.i_valid = v;
        bus4.i_data  = d[1:0];
        bus3.i_data  = d[1:0];
        bus4.o_ready = rdy;
        bus3.o_ready = rdy;
        @(posedge clk);
        model_step(v, d, rdy, rs);
        #1;
        compare_all();
    endtask

    initial begin
        int sat_exp;
        rst = 1'b0;
        bus4.i_valid = 0; bus3.i_valid = 0;
        bus4.i_data = 0;  bus3.i_data = 0;
        bus4.o_ready = 1; bus3.o_ready = 1;

        // Reset state
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("rst_valid", 32'(bus4.o_valid), 0);
        chk("rst_data", 32'(bus4.o_data), 0);
        chk("rst_drop", 32'(bus4.o_drop), 0);

        // Consecutive samples 1,2,3,3 -> 9
        cycle(1, 1, 1, 1);
        cycle(1, 2, 1, 1);
        cycle(1, 3, 1, 1);
        cycle(1, 3, 1, 1);
        chk("seq_valid", 32'(bus4.o_valid), 1);
        chk("seq_data", 32'(bus4.o_data), 9);
        cycle(0, 0, 1, 1);
        chk("seq_clear", 32'(bus4.o_valid), 0);

        // Samples 1,0,2,1 with two idle cycles between each -> 4
        foreach (q_grp[i]) ;
        begin
            int s[4] = '{1, 0, 2, 1};
            for (int i = 0; i < 4; i++) begin
                cycle(1, s[i], 1, 1);
                if (i < 3) begin
                    cycle(0, 0, 1, 1);
                    cycle(0, 0, 1, 1);
                end
            end
        end
        chk("gap_data", 32'(bus4.o_data), 4);
        cycle(0, 0, 1, 1);

        // Backpressure: hold 5, drop 8, then accept 5
        cycle(1, 1, 0, 1); cycle(1, 1, 0, 1); cycle(1, 1, 0, 1); cycle(1, 2, 0, 1);
        chk("bp_first", 32'(bus4.o_data), 5);
        cycle(1, 2, 0, 1); cycle(1, 2, 0, 1); cycle(1, 2, 0, 1); cycle(1, 2, 0, 1);
        chk("bp_drop", 32'(bus4.o_drop), 1);
        chk("bp_hold", 32'(bus4.o_data), 5);
        cycle(0, 0, 0, 1);
        chk("bp_drop_end", 32'(bus4.o_drop), 0);
        cycle(0, 0, 1, 1);
        chk("bp_accept", 32'(bus4.o_valid), 0);

        // Held 5 accepted in the same cycle a 7 completes
        cycle(1, 1, 0, 1); cycle(1, 1, 0, 1); cycle(1, 1, 0, 1); cycle(1, 2, 0, 1);
        cycle(1, 2, 0, 1); cycle(1, 2, 0, 1); cycle(1, 2, 0, 1); cycle(1, 1, 1, 1);
        chk("swap_valid", 32'(bus4.o_valid), 1);
        chk("swap_data", 32'(bus4.o_data), 7);
        chk("swap_drop", 32'(bus4.o_drop), 0);
        cycle(0, 0, 1, 1);

        // Partial group abandoned by reset
        cycle(1, 3, 1, 1); cycle(1, 3, 1, 1);
        cycle(0, 0, 1, 0);
        cycle(1, 1, 1, 1); cycle(1, 1, 1, 1); cycle(1, 1, 1, 1);
        chk("abort_none", 32'(bus4.o_valid), 0);
        cycle(1, 1, 1, 1);
        chk("abort_data", 32'(bus4.o_data), 4);
        cycle(0, 0, 1, 1);

        // Overflow at OUT_WIDTH=3
        cycle(1, 3, 1, 1); cycle(1, 3, 1, 1); cycle(1, 3, 1, 1); cycle(1, 3, 1, 1);
        sat_exp = SAT ? 7 : 4;
        chk("ovf_data3", 32'(bus3.o_data), sat_exp);
        chk("ovf_data4", 32'(bus4.o_data), 12);
        cycle(0, 0, 1, 1);

        // Random traffic with backpressure and occasional reset
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 59) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
